// File: rtl/dcache_line_xfer.sv
// dcache_line_xfer: dirty-victim write-back then line refill over a beat-serial bus.
// Define DCACHE_XFER_PERF_EN to add the o_wb_count / o_refill_count event counters.
module dcache_line_xfer #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_start,
    input  logic                  i_dirty,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_wb,
    input  logic [LINE_WIDTH-1:0] i_data_wb,
    output logic                  o_busy,
    output logic                  o_block_we,
    output logic [LINE_WIDTH-1:0] o_data_block,
    output logic                  o_done,
    output logic                  o_mem_avalid,
    input  logic                  i_mem_aready,
    output logic                  o_mem_awrite,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [BEAT_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_wlast,
    input  logic                  i_mem_rvalid,
    output logic                  o_mem_rready,
    input  logic [BEAT_WIDTH-1:0] i_mem_rdata
`ifdef DCACHE_XFER_PERF_EN
    ,
    output logic [31:0]           o_wb_count,
    output logic [31:0]           o_refill_count
`endif
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LMASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        IDLE, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, FILL, DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [LINE_WIDTH-1:0] wb_buf;
    logic [LINE_WIDTH-1:0] fill_buf;
    logic [LINE_WIDTH-1:0] fill_nx;

    assign cnt_inc = cnt + CW'(1);

    // fill_nx lets the last beat reach o_data_block in the same edge it lands
    always_comb begin
        fill_nx = fill_buf;
        fill_nx[cnt*BEAT_WIDTH +: BEAT_WIDTH] = i_mem_rdata;
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state        <= IDLE;
            cnt          <= '0;
            miss_addr    <= '0;
            wb_buf       <= '0;
            fill_buf     <= '0;
            o_busy       <= 1'b0;
            o_block_we   <= 1'b0;
            o_data_block <= '0;
            o_done       <= 1'b0;
            o_mem_avalid <= 1'b0;
            o_mem_awrite <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wvalid <= 1'b0;
            o_mem_wdata  <= '0;
            o_mem_wlast  <= 1'b0;
            o_mem_rready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    miss_addr    <= i_addr & LMASK;
                    wb_buf       <= i_data_wb;
                    o_busy       <= 1'b1;
                    o_mem_avalid <= 1'b1;
                    o_mem_awrite <= i_dirty;
                    o_mem_addr   <= (i_dirty ? i_addr_wb : i_addr) & LMASK;
                    state        <= i_dirty ? WB_ADDR : RF_ADDR;
                end
                WB_ADDR: if (i_mem_aready) begin
                    o_mem_avalid <= 1'b0;
                    o_mem_awrite <= 1'b0;
                    o_mem_wvalid <= 1'b1;
                    o_mem_wdata  <= wb_buf[BEAT_WIDTH-1:0];
                    o_mem_wlast  <= 1'b0;
                    state        <= WB_DATA;
                end
                WB_DATA: if (i_mem_wready) begin
                    if (cnt == LAST) begin
                        cnt          <= '0;
                        o_mem_wvalid <= 1'b0;
                        o_mem_wlast  <= 1'b0;
                        o_mem_avalid <= 1'b1;
                        o_mem_addr   <= miss_addr;
                        state        <= RF_ADDR;
                    end else begin
                        cnt         <= cnt_inc;
                        o_mem_wdata <= wb_buf[cnt_inc*BEAT_WIDTH +: BEAT_WIDTH];
                        o_mem_wlast <= (cnt_inc == LAST);
                    end
                end
                RF_ADDR: if (i_mem_aready) begin
                    o_mem_avalid <= 1'b0;
                    o_mem_rready <= 1'b1;
                    state        <= RF_DATA;
                end
                RF_DATA: if (i_mem_rvalid) begin
                    fill_buf <= fill_nx;
                    if (cnt == LAST) begin
                        cnt          <= '0;
                        o_mem_rready <= 1'b0;
                        o_block_we   <= 1'b1;
                        o_data_block <= fill_nx;
                        state        <= FILL;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                FILL: begin
                    o_block_we <= 1'b0;
                    o_done     <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_XFER_PERF_EN
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_wb_count     <= '0;
            o_refill_count <= '0;
        end else begin
            if (state == WB_DATA && i_mem_wready && cnt == LAST)
                o_wb_count <= o_wb_count + 32'd1;
            if (state == RF_DATA && i_mem_rvalid && cnt == LAST)
                o_refill_count <= o_refill_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_line_xfer.sv
// tb_dcache_line_xfer: randomized memory responder plus transaction-level line model.
// Build with DCACHE_XFER_PERF_EN defined to also check the event counters.
module tb_dcache_line_xfer;

    logic         i_clk;
    logic         i_arstn;
    logic         i_start;
    logic         i_dirty;
    logic [63:0]  i_addr;
    logic [63:0]  i_addr_wb;
    logic [511:0] i_data_wb;
    logic         o_busy;
    logic         o_block_we;
    logic [511:0] o_data_block;
    logic         o_done;
    logic         o_mem_avalid;
    logic         i_mem_aready;
    logic         o_mem_awrite;
    logic [63:0]  o_mem_addr;
    logic         o_mem_wvalid;
    logic         i_mem_wready;
    logic [63:0]  o_mem_wdata;
    logic         o_mem_wlast;
    logic         i_mem_rvalid;
    logic         o_mem_rready;
    logic [63:0]  i_mem_rdata;
`ifdef DCACHE_XFER_PERF_EN
    logic [31:0]  o_wb_count;
    logic [31:0]  o_refill_count;
    int           exp_wb;
    int           exp_rf;
`endif

    dcache_line_xfer dut (
        .i_clk(i_clk), .i_arstn(i_arstn),
        .i_start(i_start), .i_dirty(i_dirty),
        .i_addr(i_addr), .i_addr_wb(i_addr_wb), .i_data_wb(i_data_wb),
        .o_busy(o_busy), .o_block_we(o_block_we),
        .o_data_block(o_data_block), .o_done(o_done),
        .o_mem_avalid(o_mem_avalid), .i_mem_aready(i_mem_aready),
        .o_mem_awrite(o_mem_awrite), .o_mem_addr(o_mem_addr),
        .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready),
        .o_mem_wdata(o_mem_wdata), .o_mem_wlast(o_mem_wlast),
        .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
        .i_mem_rdata(i_mem_rdata)
`ifdef DCACHE_XFER_PERF_EN
        ,
        .o_wb_count(o_wb_count),
        .o_refill_count(o_refill_count)
`endif
    );

    localparam logic [63:0] AMASK = ~64'h3f;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // responder knobs: a_delay<0 means random aready
    int a_delay = 0;
    int w_mode = 0;
    int r_mode = 0;
    int mem_mode = 0;

    // monitor record
    logic [64:0]  aq[$];
    logic [64:0]  wq[$];
    logic [511:0] lq[$];
    int           lcyc[$];
    int           dcyc[$];
    int           rbeats = 0;
    int           stab_err = 0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_beat(input logic [63:0] a,
                                             input int k, input int mode);
        if (mode == 0) return 64'(k);
        return {a[31:0] ^ 32'h9e3779b9, 16'hbeef, 16'(k)};
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // memory responder + bus monitor
    initial begin
        int a_wait = 0;
        int rbeat = 0;
        int r_ph = 0;
        bit w_tog = 1'b0;
        bit rd_active = 1'b0;
        logic [63:0] rd_addr = '0;
        bit pa = 1'b0;
        bit pw = 1'b0;
        logic [64:0] pa_v = '0;
        logic [64:0] pw_v = '0;
        i_mem_aready = 1'b0;
        i_mem_wready = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (!i_arstn) begin
                rd_active = 1'b0;
                rbeat = 0;
                a_wait = 0;
                pa = 1'b0;
                pw = 1'b0;
            end
            if (a_delay < 0)
                i_mem_aready = 1'($urandom_range(0, 1));
            else if (o_mem_avalid && a_wait < a_delay) begin
                i_mem_aready = 1'b0;
                a_wait++;
            end else
                i_mem_aready = 1'b1;
            w_tog = ~w_tog;
            case (w_mode)
                0: i_mem_wready = 1'b1;
                1: i_mem_wready = w_tog;
                default: i_mem_wready = 1'($urandom_range(0, 1));
            endcase
            case (r_mode)
                0: i_mem_rvalid = 1'b1;
                1: begin
                    i_mem_rvalid = (r_ph == 0);
                    r_ph = (r_ph == 2) ? 0 : r_ph + 1;
                end
                default: i_mem_rvalid = 1'($urandom_range(0, 1));
            endcase
            if (rd_active)
                i_mem_rdata = mem_beat(rd_addr, rbeat, mem_mode);
            else
                i_mem_rdata = {$urandom, $urandom};
            #1;
            if (i_arstn) begin
                if (pa && {o_mem_avalid, o_mem_awrite, o_mem_addr} !== {1'b1, pa_v})
                    stab_err++;
                if (pw && {o_mem_wvalid, o_mem_wlast, o_mem_wdata} !== {1'b1, pw_v})
                    stab_err++;
                pa = o_mem_avalid && !i_mem_aready;
                pa_v = {o_mem_awrite, o_mem_addr};
                pw = o_mem_wvalid && !i_mem_wready;
                pw_v = {o_mem_wlast, o_mem_wdata};
                if (o_mem_avalid && i_mem_aready) begin
                    aq.push_back({o_mem_awrite, o_mem_addr});
                    a_wait = 0;
                    if (!o_mem_awrite) begin
                        rd_active = 1'b1;
                        rd_addr = o_mem_addr;
                        rbeat = 0;
                    end
                end
                if (o_mem_wvalid && i_mem_wready)
                    wq.push_back({o_mem_wlast, o_mem_wdata});
                if (o_mem_rready && i_mem_rvalid) begin
                    rbeats++;
                    rbeat++;
                    if (rbeat == 8) rd_active = 1'b0;
                end
            end
            if (o_block_we) begin
                lq.push_back(o_data_block);
                lcyc.push_back(cyc);
            end
            if (o_done) dcyc.push_back(cyc);
        end
    end

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, 512'({o_busy, o_block_we, o_done, o_mem_avalid,
            o_mem_awrite, o_mem_wvalid, o_mem_wlast, o_mem_rready}), 512'(0));
        chk({tag, "_addr"}, 512'(o_mem_addr), 512'(0));
        chk({tag, "_wdata"}, 512'(o_mem_wdata), 512'(0));
        chk({tag, "_line"}, o_data_block, 512'(0));
`ifdef DCACHE_XFER_PERF_EN
        chk({tag, "_perf"}, 512'({o_wb_count, o_refill_count}), 512'(0));
`endif
    endtask

    task automatic run_miss(input logic [63:0] a, input logic [63:0] awb,
                            input logic [511:0] dwb, input logic d,
                            input bit poke, input int lat);
        int ab, wb, lb, db, rb0, se0, t0, ri;
        logic [511:0] line;
        ab = aq.size();
        wb = wq.size();
        lb = lq.size();
        db = dcyc.size();
        rb0 = rbeats;
        se0 = stab_err;
        @(negedge i_clk);
        i_start = 1'b1;
        i_dirty = d;
        i_addr = a;
        i_addr_wb = awb;
        i_data_wb = dwb;
        t0 = cyc;
        for (int n = 0; n < 800; n++) begin
            @(negedge i_clk);
            i_start = poke && (o_mem_wvalid || o_block_we);
            i_dirty = 1'($urandom_range(0, 1));
            i_addr = {$urandom, $urandom};
            i_addr_wb = {$urandom, $urandom};
            #2;
            if (dcyc.size() > db) break;
        end
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        #2;
        for (int k = 0; k < 8; k++)
            line[k*64 +: 64] = mem_beat(a & AMASK, k, mem_mode);
`ifdef DCACHE_XFER_PERF_EN
        exp_rf++;
        if (d) exp_wb++;
`endif
        chk("done_cnt", 512'(dcyc.size() - db), 512'(1));
        chk("bwe_cnt", 512'(lq.size() - lb), 512'(1));
        chk("addr_cnt", 512'(aq.size() - ab), 512'(d ? 2 : 1));
        chk("wbeat_cnt", 512'(wq.size() - wb), 512'(d ? 8 : 0));
        chk("rbeat_cnt", 512'(rbeats - rb0), 512'(8));
        chk("stable", 512'(stab_err - se0), 512'(0));
        chk("busy_idle", 512'(o_busy), 512'(0));
        chk("line_hold", o_data_block, line);
        if (lq.size() > lb) begin
            chk("line", lq[lb], line);
            if (dcyc.size() > db)
                chk("done_after_bwe", 512'(dcyc[db] - lcyc[lb]), 512'(1));
            if (lat >= 0)
                chk("bwe_lat", 512'(lcyc[lb] - t0), 512'(lat));
        end
        if (d && aq.size() > ab)
            chk("wb_addr", 512'(aq[ab]), 512'({1'b1, awb & AMASK}));
        ri = ab + (d ? 1 : 0);
        if (aq.size() > ri)
            chk("rf_addr", 512'(aq[ri]), 512'({1'b0, a & AMASK}));
        if (d && wq.size() >= wb + 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("wbeat%0d", k), 512'(wq[wb+k]),
                    512'({k == 7, dwb[k*64 +: 64]}));
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [511:0] dwb;
        int rb0, lb, db;
        i_arstn = 1'b0;
        i_start = 1'b0;
        i_dirty = 1'b0;
        i_addr = '0;
        i_addr_wb = '0;
        i_data_wb = '0;
`ifdef DCACHE_XFER_PERF_EN
        exp_wb = 0;
        exp_rf = 0;
`endif
        repeat (3) @(negedge i_clk);
        #1;
        chk_outs_zero("reset");
        @(negedge i_clk);
        i_arstn = 1'b1;

        // clean miss, beat-index data, zero wait
        run_miss(64'h1234, 64'h0, 512'h0, 1'b0, 1'b0, 10);

        // dirty miss with toggling wready
        mem_mode = 1;
        w_mode = 1;
        for (int k = 0; k < 8; k++) dwb[k*64 +: 64] = 64'(8'hA0 + k);
        run_miss(64'h0000_0000_0003_1f08, 64'h8040, dwb, 1'b1, 1'b0, -1);

        // dirty miss, zero wait
        w_mode = 0;
        run_miss({$urandom, $urandom}, {$urandom, $urandom}, rand_line(),
                 1'b1, 1'b0, 19);

        // rvalid gaps and slow address acceptance
        a_delay = 3;
        r_mode = 1;
        run_miss(64'h0000_7777_0000_0010, 64'h0, 512'h0, 1'b0, 1'b0, -1);

        // reset in the middle of a refill
        a_delay = 0;
        r_mode = 0;
        rb0 = rbeats;
        lb = lq.size();
        db = dcyc.size();
        @(negedge i_clk);
        i_start = 1'b1;
        i_dirty = 1'b0;
        i_addr = 64'h0000_1234_5678_9ac0;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int n = 0; n < 50 && (rbeats - rb0) < 5; n++) begin
            @(negedge i_clk);
            #2;
        end
        chk("abort_progress", 512'((rbeats - rb0) >= 5), 512'(1));
        i_arstn = 1'b0;
        #1;
        chk_outs_zero("abort_rst");
`ifdef DCACHE_XFER_PERF_EN
        exp_wb = 0;
        exp_rf = 0;
`endif
        repeat (2) @(negedge i_clk);
        #2;
        chk("abort_bwe", 512'(lq.size() - lb), 512'(0));
        chk("abort_done", 512'(dcyc.size() - db), 512'(0));
        @(negedge i_clk);
        i_arstn = 1'b1;
        run_miss(64'h0000_0000_00ab_cd40, 64'h0, 512'h0, 1'b0, 1'b0, 10);

        // i_start pulses in WB_DATA and FILL must be ignored
        w_mode = 1;
        run_miss({$urandom, $urandom}, {$urandom, $urandom}, rand_line(),
                 1'b1, 1'b1, -1);

        // randomized misses and bus timing
        for (int t = 0; t < 16; t++) begin
            a_delay = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 2));
            w_mode = int'($urandom_range(0, 2));
            r_mode = int'($urandom_range(0, 2));
            run_miss({$urandom, $urandom}, {$urandom, $urandom}, rand_line(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

`ifdef DCACHE_XFER_PERF_EN
        chk("wb_count", 512'(o_wb_count), 512'(exp_wb));
        chk("refill_count", 512'(o_refill_count), 512'(exp_rf));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
